// File: rtl/imfifo_pkg.sv
// imfifo_pkg: shared constants, pixel type, loader states and band clamping for the window-FIFO loader
package imfifo_pkg;

    localparam int IMF_DATA_WIDTH = 16;
    localparam int IMF_COLS       = 33;
    localparam int IMF_ROWS       = 33;

    typedef logic [IMF_DATA_WIDTH-1:0] pixel_t;

    typedef enum logic [1:0] {IDLE, FETCH, DRAIN, DONE} loader_state_t;

    // Rows actually available below base; a base past the image yields an empty band
    function automatic int clamp_rows(input int base, input int num, input int rows);
        return base >= rows ? 0 : (num < rows - base ? num : rows - base);
    endfunction

endpackage

// File: rtl/pix_skid_buf.sv
// pix_skid_buf: 2-entry pixel FIFO absorbing RAM reads already in flight when the window FIFO fills
module pix_skid_buf
    import imfifo_pkg::*;
#(
    parameter int DATA_WIDTH = IMF_DATA_WIDTH
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  flush,
    input  logic                  push,
    input  logic                  pop,
    input  logic [DATA_WIDTH-1:0] din,
    output logic [DATA_WIDTH-1:0] head,
    output logic [1:0]            count
);

    logic [DATA_WIDTH-1:0] mem_q [2];
    logic                  wp_q, rp_q;
    logic [1:0]            cnt_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst || flush) begin
            mem_q[0] <= '0;
            mem_q[1] <= '0;
            wp_q     <= 1'b0;
            rp_q     <= 1'b0;
            cnt_q    <= '0;
        end else begin
            if (push) begin
                mem_q[wp_q] <= din;
                wp_q        <= ~wp_q;
            end
            if (pop)
                rp_q <= ~rp_q;
            cnt_q <= cnt_q + 2'(push) - 2'(pop);
        end
    end

    assign head  = mem_q[rp_q];
    assign count = cnt_q;

endmodule

// File: rtl/imfifo_loader.sv
// imfifo_loader: streams a clamped band of image rows, raster order, from a sync-read RAM into the window FIFO
module imfifo_loader
    import imfifo_pkg::*;
#(
    parameter int DATA_WIDTH = IMF_DATA_WIDTH,
    parameter int COLS       = IMF_COLS,
    parameter int ROWS       = IMF_ROWS,
    parameter int ADDR_WIDTH = $clog2(COLS*ROWS),
    parameter int RB         = $clog2(ROWS+1)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  clear,
    input  logic                  start,
    input  logic [RB-1:0]         row_base,
    input  logic [RB-1:0]         num_rows,
    output logic                  mem_rd_en,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    input  logic [DATA_WIDTH-1:0] mem_rdata,
    input  logic                  full,
    output logic                  w_en,
    output logic [DATA_WIDTH-1:0] data_out,
    output logic                  busy,
    output logic                  done
);

    localparam int CW = $clog2(COLS*ROWS+1);

    loader_state_t         state_q, state_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d, lat_addr;
    logic [CW-1:0]         rd_left_q, rd_left_d;
    logic [CW-1:0]         wr_cnt_q, wr_cnt_d;
    logic [CW-1:0]         total_q, total_d, lat_total;
    logic [RB-1:0]         rows_eff;
    logic                  inflight_q;
    logic [1:0]            buf_count;
    logic                  can_read;

    assign rows_eff  = RB'(clamp_rows(int'(row_base), int'(num_rows), ROWS));
    assign lat_total = CW'(rows_eff) * CW'(COLS);
    assign lat_addr  = rows_eff == '0 ? '0 : ADDR_WIDTH'(row_base) * ADDR_WIDTH'(COLS);

    assign w_en = buf_count != 2'd0 && !full;

    // Occupancy is judged after this cycle's pop so a steady stream never stalls
    assign can_read = state_q == FETCH && rd_left_q != '0 &&
                      ({1'b0, buf_count} + {2'b0, inflight_q} - {2'b0, w_en}) < 3'd2;

    assign mem_rd_en = can_read;
    assign mem_addr  = addr_q;
    assign busy      = state_q == FETCH || state_q == DRAIN;
    assign done      = state_q == DONE;

    always_comb begin
        state_d   = state_q;
        addr_d    = addr_q;
        rd_left_d = rd_left_q;
        total_d   = total_q;
        wr_cnt_d  = wr_cnt_q + CW'(w_en);
        case (state_q)
            IDLE: if (start) begin
                state_d   = FETCH;
                addr_d    = lat_addr;
                rd_left_d = lat_total;
                total_d   = lat_total;
                wr_cnt_d  = '0;
            end
            FETCH: begin
                if (can_read) begin
                    rd_left_d = rd_left_q - CW'(1);
                    addr_d    = rd_left_q == CW'(1) ? addr_q : addr_q + ADDR_WIDTH'(1);
                end
                state_d = (rd_left_q == '0 || (can_read && rd_left_q == CW'(1))) ? DRAIN : FETCH;
            end
            DRAIN: state_d = (buf_count == 2'd0 && !inflight_q && wr_cnt_q == total_q) ? DONE : DRAIN;
            DONE:  state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst || clear) begin
            state_q    <= IDLE;
            addr_q     <= '0;
            rd_left_q  <= '0;
            wr_cnt_q   <= '0;
            total_q    <= '0;
            inflight_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            addr_q     <= addr_d;
            rd_left_q  <= rd_left_d;
            wr_cnt_q   <= wr_cnt_d;
            total_q    <= total_d;
            inflight_q <= can_read;
        end
    end

    pix_skid_buf #(.DATA_WIDTH(DATA_WIDTH)) u_skid (
        .clk   (clk),
        .rst   (rst),
        .flush (clear),
        .push  (inflight_q),
        .pop   (w_en),
        .din   (mem_rdata),
        .head  (data_out),
        .count (buf_count)
    );

endmodule

// File: tb/tb_imfifo_loader.sv
// tb_imfifo_loader: scenario tasks plus randomized bands checked against a raster-order band model
module tb_imfifo_loader;

    localparam int C   = 5;
    localparam int R   = 5;
    localparam int DW  = 16;
    localparam int AW  = $clog2(C*R);
    localparam int RBW = $clog2(R+1);

    logic           clk = 1'b0, rst = 1'b1, clear = 1'b0, start = 1'b0, full = 1'b0;
    logic [RBW-1:0] row_base = '0, num_rows = '0;
    logic           mem_rd_en, w_en, busy, done;
    logic [AW-1:0]  mem_addr;
    logic [DW-1:0]  mem_rdata = '0, data_out;

    int n_tests = 0, n_fail = 0;
    int cyc = 0, s0 = 0, done_cnt = 0, done_rel = -1, wfull = 0;
    logic [DW-1:0] got[$], exp_q[$];
    int wrel[$], ra[$];

    imfifo_loader #(.DATA_WIDTH(DW), .COLS(C), .ROWS(R)) dut (
        .clk(clk), .rst(rst), .clear(clear), .start(start),
        .row_base(row_base), .num_rows(num_rows),
        .mem_rd_en(mem_rd_en), .mem_addr(mem_addr), .mem_rdata(mem_rdata),
        .full(full), .w_en(w_en), .data_out(data_out),
        .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (mem_rd_en) mem_rdata <= 16'(mem_addr) + 16'd100;
    end

    always @(negedge clk) begin
        if (w_en) begin
            got.push_back(data_out);
            wrel.push_back(cyc - s0);
        end
        if (w_en && full) wfull++;
        if (mem_rd_en) ra.push_back(int'(mem_addr));
        if (done) begin
            if (done_cnt == 0) done_rel = cyc - s0;
            done_cnt++;
        end
    end

    function automatic void build_exp(input int rb, input int nr);
        int re;
        exp_q.delete();
        re = rb >= R ? 0 : (nr < R - rb ? nr : R - rb);
        for (int r = rb; r < rb + re; r++)
            for (int c = 0; c < C; c++)
                exp_q.push_back(16'(r*C + c + 100));
    endfunction

    task automatic kick(input int rb, input int nr);
        @(posedge clk); #1;
        got.delete(); wrel.delete(); ra.delete();
        done_cnt = 0; done_rel = -1; wfull = 0;
        row_base = RBW'(rb); num_rows = RBW'(nr); start = 1'b1; s0 = cyc;
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    task automatic wait_done(input int fm, output bit to);
        to = 1'b1;
        for (int i = 0; i < 400; i++) begin
            full = (fm == 1 && cyc - s0 >= 5 && cyc - s0 <= 8) || (fm == 2 && $urandom_range(0, 2) == 0);
            @(posedge clk); #1;
            if (done_cnt > 0) begin
                to = 1'b0;
                break;
            end
        end
        full = 1'b0;
        repeat (3) @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        repeat (2) @(posedge clk);
        #1;
        n_tests++;
        if ({mem_rd_en, w_en, busy, done, mem_addr, data_out} !== '0) begin
            n_fail++; $display("FAIL reset_outputs got %h required 0", {mem_rd_en, w_en, busy, done, mem_addr, data_out});
        end
        rst = 1'b0;
        @(negedge clk);
        n_tests++;
        if ({busy, w_en, mem_rd_en} !== 3'b000) begin
            n_fail++; $display("FAIL reset_idle got %b required 000", {busy, w_en, mem_rd_en});
        end
    endtask

    task automatic test_stream();
        bit to;
        kick(1, 3);
        wait_done(0, to);
        build_exp(1, 3);
        n_tests++;
        if (to) begin n_fail++; $display("FAIL stream_timeout got no done required done"); end
        n_tests++;
        if (got.size() !== exp_q.size()) begin
            n_fail++; $display("FAIL stream_len got %0d required %0d", got.size(), exp_q.size());
        end else foreach (exp_q[i]) begin
            n_tests++;
            if (got[i] !== exp_q[i]) begin n_fail++; $display("FAIL stream_data[%0d] got %0d required %0d", i, got[i], exp_q[i]); end
            n_tests++;
            if (wrel[i] !== 3 + i) begin n_fail++; $display("FAIL stream_wcycle[%0d] got %0d required %0d", i, wrel[i], 3 + i); end
        end
        n_tests++;
        if (done_cnt !== 1) begin n_fail++; $display("FAIL stream_done_count got %0d required 1", done_cnt); end
        n_tests++;
        if (ra.size() !== 15) begin
            n_fail++; $display("FAIL stream_reads got %0d required 15", ra.size());
        end else begin
            n_tests++;
            if (ra[0] !== 5 || ra[14] !== 19) begin n_fail++; $display("FAIL stream_addr_range got %0d..%0d required 5..19", ra[0], ra[14]); end
        end
    endtask

    task automatic test_full_window();
        bit to;
        kick(1, 3);
        wait_done(1, to);
        build_exp(1, 3);
        n_tests++;
        if (to) begin n_fail++; $display("FAIL fullwin_timeout got no done required done"); end
        n_tests++;
        if (wfull !== 0) begin n_fail++; $display("FAIL fullwin_write_while_full got %0d required 0", wfull); end
        n_tests++;
        if (got.size() !== exp_q.size()) begin
            n_fail++; $display("FAIL fullwin_len got %0d required %0d", got.size(), exp_q.size());
        end else foreach (exp_q[i]) begin
            n_tests++;
            if (got[i] !== exp_q[i]) begin n_fail++; $display("FAIL fullwin_data[%0d] got %0d required %0d", i, got[i], exp_q[i]); end
            n_tests++;
            if (wrel[i] !== (i < 2 ? 3 + i : 7 + i)) begin
                n_fail++; $display("FAIL fullwin_wcycle[%0d] got %0d required %0d", i, wrel[i], i < 2 ? 3 + i : 7 + i);
            end
        end
    endtask

    task automatic test_clamp();
        bit to;
        kick(3, 4);
        wait_done(0, to);
        build_exp(3, 4);
        n_tests++;
        if (to) begin n_fail++; $display("FAIL clamp_timeout got no done required done"); end
        n_tests++;
        if (got.size() !== exp_q.size()) begin
            n_fail++; $display("FAIL clamp_len got %0d required %0d", got.size(), exp_q.size());
        end else foreach (exp_q[i]) begin
            n_tests++;
            if (got[i] !== exp_q[i]) begin n_fail++; $display("FAIL clamp_data[%0d] got %0d required %0d", i, got[i], exp_q[i]); end
        end
        n_tests++;
        if (ra.size() !== 10) begin
            n_fail++; $display("FAIL clamp_reads got %0d required 10", ra.size());
        end else begin
            n_tests++;
            if (ra[9] !== 24) begin n_fail++; $display("FAIL clamp_max_addr got %0d required 24", ra[9]); end
        end
    endtask

    task automatic test_zero();
        bit to;
        for (int k = 0; k < 2; k++) begin
            kick(k == 0 ? 2 : 6, k == 0 ? 0 : 3);
            wait_done(0, to);
            n_tests++;
            if (to) begin n_fail++; $display("FAIL zero%0d_timeout got no done required done", k); end
            n_tests++;
            if (ra.size() !== 0 || got.size() !== 0) begin
                n_fail++; $display("FAIL zero%0d_activity got reads %0d writes %0d required 0 0", k, ra.size(), got.size());
            end
            n_tests++;
            if (done_rel !== 3 || done_cnt !== 1) begin
                n_fail++; $display("FAIL zero%0d_done got cycle %0d count %0d required cycle 3 count 1", k, done_rel, done_cnt);
            end
        end
    endtask

    task automatic test_rst_mid();
        bit to;
        kick(0, 5);
        for (int i = 0; i < 60; i++) begin
            @(negedge clk);
            if (got.size() >= 6) break;
        end
        n_tests++;
        if (got.size() !== 6) begin n_fail++; $display("FAIL rstmid_writes got %0d required 6", got.size()); end
        #2 rst = 1'b1;
        @(posedge clk); #1;
        n_tests++;
        if ({mem_rd_en, w_en, busy, done, mem_addr, data_out} !== '0) begin
            n_fail++; $display("FAIL rstmid_outputs got %h required 0", {mem_rd_en, w_en, busy, done, mem_addr, data_out});
        end
        rst = 1'b0;
        repeat (20) @(posedge clk);
        n_tests++;
        if (done_cnt !== 0) begin n_fail++; $display("FAIL rstmid_no_done got %0d required 0", done_cnt); end
        kick(0, 1);
        wait_done(0, to);
        build_exp(0, 1);
        n_tests++;
        if (to || got.size() !== exp_q.size()) begin
            n_fail++; $display("FAIL rstmid_restart_len got %0d required %0d", got.size(), exp_q.size());
        end else foreach (exp_q[i]) begin
            n_tests++;
            if (got[i] !== exp_q[i]) begin n_fail++; $display("FAIL rstmid_data[%0d] got %0d required %0d", i, got[i], exp_q[i]); end
        end
    endtask

    task automatic test_back_to_back_start();
        bit to;
        kick(1, 3);
        repeat (3) @(posedge clk);
        #1;
        row_base = RBW'(0); num_rows = RBW'(2); start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        wait_done(0, to);
        build_exp(1, 3);
        n_tests++;
        if (to || done_cnt !== 1) begin n_fail++; $display("FAIL restart_done got %0d required 1", done_cnt); end
        n_tests++;
        if (got.size() !== exp_q.size()) begin
            n_fail++; $display("FAIL restart_len got %0d required %0d", got.size(), exp_q.size());
        end else foreach (exp_q[i]) begin
            n_tests++;
            if (got[i] !== exp_q[i]) begin n_fail++; $display("FAIL restart_data[%0d] got %0d required %0d", i, got[i], exp_q[i]); end
        end
    endtask

    task automatic test_clear();
        bit to;
        kick(0, 5);
        repeat (8) @(posedge clk);
        #1 clear = 1'b1;
        @(posedge clk); #1;
        clear = 1'b0;
        n_tests++;
        if ({busy, w_en, mem_rd_en, mem_addr} !== '0) begin
            n_fail++; $display("FAIL clear_outputs got %h required 0", {busy, w_en, mem_rd_en, mem_addr});
        end
        repeat (60) @(posedge clk);
        n_tests++;
        if (done_cnt !== 0 || got.size() >= 25) begin
            n_fail++; $display("FAIL clear_abort got done %0d writes %0d required 0 and <25", done_cnt, got.size());
        end
        kick(4, 1);
        wait_done(0, to);
        build_exp(4, 1);
        n_tests++;
        if (to || got.size() !== exp_q.size()) begin
            n_fail++; $display("FAIL clear_recover_len got %0d required %0d", got.size(), exp_q.size());
        end else foreach (exp_q[i]) begin
            n_tests++;
            if (got[i] !== exp_q[i]) begin n_fail++; $display("FAIL clear_recover_data[%0d] got %0d required %0d", i, got[i], exp_q[i]); end
        end
    endtask

    task automatic test_random();
        bit to;
        int rb, nr;
        for (int t = 0; t < 8; t++) begin
            rb = $urandom_range(0, 6);
            nr = $urandom_range(0, 7);
            kick(rb, nr);
            wait_done(2, to);
            build_exp(rb, nr);
            n_tests++;
            if (to || done_cnt !== 1) begin n_fail++; $display("FAIL rand%0d_done rb=%0d nr=%0d got %0d required 1", t, rb, nr, done_cnt); end
            n_tests++;
            if (wfull !== 0) begin n_fail++; $display("FAIL rand%0d_write_while_full got %0d required 0", t, wfull); end
            n_tests++;
            if (ra.size() !== exp_q.size()) begin n_fail++; $display("FAIL rand%0d_reads got %0d required %0d", t, ra.size(), exp_q.size()); end
            n_tests++;
            if (got.size() !== exp_q.size()) begin
                n_fail++; $display("FAIL rand%0d_len rb=%0d nr=%0d got %0d required %0d", t, rb, nr, got.size(), exp_q.size());
            end else foreach (exp_q[i]) begin
                n_tests++;
                if (got[i] !== exp_q[i]) begin n_fail++; $display("FAIL rand%0d_data[%0d] got %0d required %0d", t, i, got[i], exp_q[i]); end
            end
        end
    endtask

    initial begin
        test_reset();
        test_stream();
        test_full_window();
        test_clamp();
        test_zero();
        test_rst_mid();
        test_back_to_back_start();
        test_clear();
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
